// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode encodings and PWM width for the LED pattern generator
package led_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } led_mode_e;

  localparam int PWM_W = 8;

endpackage

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - free-running PWM counter and duty comparator for BREATHE mode
module led_pwm
  import led_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty,
  output logic             on
);

  logic [PWM_W-1:0] pwm_cnt;

  // Runs every cycle regardless of pause so the PWM carrier never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign on = (pwm_cnt < duty);

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern generator: prescaler, mode register, pattern FSM, led register
// BREATHE mode and its PWM logic are compiled in only with LED_PATTERN_BREATHE_EN.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LED        = 8,
  parameter int TICK_DIV     = 4194304,
  parameter int BREATHE_STEP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int POS_W = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LED - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  led_mode_e        act_q, act_d, req_mode;
  logic [N_LED-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_up_q, dir_up_d;
  logic [N_LED-1:0] led_d;

`ifdef LED_PATTERN_BREATHE_EN
  localparam logic [PWM_W:0] STEP    = (PWM_W + 1)'(BREATHE_STEP);
  localparam logic [PWM_W:0] PWM_MAX = {1'b0, {PWM_W{1'b1}}};

  logic [PWM_W-1:0] duty_q, duty_d;
  logic             ramp_up_q, ramp_up_d;
  logic [PWM_W:0]   duty_up;
  logic             pwm_on;

  assign duty_up  = {1'b0, duty_q} + STEP;
  assign req_mode = led_mode_e'(mode);

  led_pwm u_pwm (
    .clk  (clk),
    .rst  (rst),
    .duty (duty_q),
    .on   (pwm_on)
  );
`else
  // Without BREATHE support, mode 2 is folded into OFF at the mode register.
  assign req_mode = (led_mode_e'(mode) == MODE_BREATHE) ? MODE_OFF : led_mode_e'(mode);
`endif

  assign tick = (pre_q == PRE_MAX) && !pause;

  always_comb begin
    pre_d    = pre_q;
    act_d    = act_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
`ifdef LED_PATTERN_BREATHE_EN
    duty_d    = duty_q;
    ramp_up_d = ramp_up_q;
`endif
    if (!pause) pre_d = tick ? '0 : pre_q + 1'b1;

    if (tick) begin
      if (req_mode != act_q) begin
        // A mode switch restarts the pattern instead of advancing it.
        act_d    = req_mode;
        cnt_d    = '0;
        pos_d    = '0;
        dir_up_d = 1'b1;
`ifdef LED_PATTERN_BREATHE_EN
        duty_d    = '0;
        ramp_up_d = 1'b1;
`endif
      end else begin
        case (act_q)
          MODE_COUNT: cnt_d = cnt_q + 1'b1;
          MODE_SCAN: begin
            if (N_LED == 1) begin
              pos_d = '0;
            end else if (dir_up_q) begin
              if (pos_q == POS_MAX) begin
                dir_up_d = 1'b0;
                pos_d    = pos_q - 1'b1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                dir_up_d = 1'b1;
                pos_d    = pos_q + 1'b1;
              end else begin
                pos_d = pos_q - 1'b1;
              end
            end
          end
`ifdef LED_PATTERN_BREATHE_EN
          MODE_BREATHE: begin
            // Reversing on saturation holds each endpoint for a single tick.
            if (ramp_up_q) begin
              if (duty_up >= PWM_MAX) begin
                duty_d    = PWM_MAX[PWM_W-1:0];
                ramp_up_d = 1'b0;
              end else begin
                duty_d = duty_up[PWM_W-1:0];
              end
            end else begin
              if ({1'b0, duty_q} <= STEP) begin
                duty_d    = '0;
                ramp_up_d = 1'b1;
              end else begin
                duty_d = duty_q - STEP[PWM_W-1:0];
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end

    led_d = '0;
    case (act_q)
      MODE_COUNT:   led_d = cnt_q;
      MODE_SCAN:    led_d = N_LED'(1) << pos_q;
`ifdef LED_PATTERN_BREATHE_EN
      MODE_BREATHE: led_d = {N_LED{pwm_on}};
`endif
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      act_q     <= MODE_COUNT;
      cnt_q     <= '0;
      pos_q     <= '0;
      dir_up_q  <= 1'b1;
      led       <= '0;
`ifdef LED_PATTERN_BREATHE_EN
      duty_q    <= '0;
      ramp_up_q <= 1'b1;
`endif
    end else begin
      pre_q     <= pre_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      dir_up_q  <= dir_up_d;
      led       <= led_d;
`ifdef LED_PATTERN_BREATHE_EN
      duty_q    <= duty_d;
      ramp_up_q <= ramp_up_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen with a tick-level reference model
module tb_led_pattern_gen;

  localparam int N_LED        = 4;
  localparam int TICK_DIV     = 4;
  localparam int BREATHE_STEP = 64;
`ifdef LED_PATTERN_BREATHE_EN
  localparam bit BREATHE_EN = 1'b1;
`else
  localparam bit BREATHE_EN = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic [1:0]       mode  = 2'd0;
  logic             pause = 1'b0;
  logic [N_LED-1:0] led;
  logic             tick;

  led_pattern_gen #(
    .N_LED        (N_LED),
    .TICK_DIV     (TICK_DIV),
    .BREATHE_STEP (BREATHE_STEP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .mode  (mode),
    .pause (pause),
    .led   (led),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: prescaler as an integer, pattern as step indices.
  int               m_pre, m_act, m_cnt, m_step, m_didx, m_pwm;
  logic [N_LED-1:0] m_led;
  int               duty_tab [8];

  typedef struct packed {
    logic [1:0]       mode;
    logic [N_LED-1:0] led;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int scan_pos(input int s);
    int p, r;
    if (N_LED == 1) return 0;
    p = 2 * (N_LED - 1);
    r = s % p;
    return (r < N_LED) ? r : p - r;
  endfunction

  function automatic logic [N_LED-1:0] model_led();
    case (m_act)
      0: return N_LED'(m_cnt);
      1: return N_LED'(1) << scan_pos(m_step);
      2: return (BREATHE_EN && (m_pwm < duty_tab[m_didx])) ? {N_LED{1'b1}} : {N_LED{1'b0}};
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_pre = 0; m_act = 0; m_cnt = 0; m_step = 0; m_didx = 0; m_pwm = 0; m_led = '0;
  endtask

  task automatic model_edge(input int m, input bit p, input bit tk);
    logic [N_LED-1:0] nl;
    nl    = model_led();
    m_pwm = (m_pwm + 1) % 256;
    if (!p) m_pre = tk ? 0 : m_pre + 1;
    if (tk) begin
      if (m != m_act) begin
        m_act = m; m_cnt = 0; m_step = 0; m_didx = 0;
      end else begin
        case (m_act)
          0: m_cnt = (m_cnt + 1) % (1 << N_LED);
          1: m_step++;
          2: m_didx = (m_didx + 1) % 8;
          default: ;
        endcase
      end
    end
    m_led = nl;
  endtask

  // One clock: drive at negedge, check tick before the edge, check led after it.
  task automatic cycle(input logic [1:0] m, input logic p, output logic tk);
    bit et;
    mode  = m;
    pause = p;
    #1;
    et = (m_pre == TICK_DIV - 1) && !p;
    tk = tick;
    chk("tick", tick, et);
    @(posedge clk);
    model_edge(m, p, et);
    @(negedge clk);
    chk("led", led, m_led);
  endtask

  task automatic cyc(input logic [1:0] m, input logic p);
    logic tk;
    cycle(m, p, tk);
  endtask

  task automatic to_tick(input logic [1:0] m);
    while (m_pre != TICK_DIV - 1) cyc(m, 1'b0);
    cyc(m, 1'b0);
  endtask

  task automatic add_vec(input logic [1:0] m, input logic [N_LED-1:0] l);
    vec_t v;
    v.mode = m;
    v.led  = l;
    vt.push_back(v);
  endtask

  initial begin
    logic             tk;
    int               n, hi;
    logic [1:0]       cur, rm;
    logic [N_LED-1:0] hold;
    logic [N_LED-1:0] scan_exp [8];
    int               breathe_exp [10];
    int               hold_pts [2];

    duty_tab    = '{0, 64, 128, 192, 255, 191, 127, 63};
    scan_exp    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    breathe_exp = '{0, 64, 128, 192, 255, 191, 127, 63, 0, 64};
    hold_pts    = '{1, TICK_DIV - 1};
    model_reset();

    repeat (2) @(negedge clk);
    chk("reset_led", led, 0);
    chk("reset_tick", tick, 0);
    rst = 1'b0;

    // Tick cadence right after release: cycles 4 and 8.
    for (int i = 1; i <= 2 * TICK_DIV; i++) begin
      cycle(2'd0, 1'b0, tk);
      chk("tick_cadence", tk, (i % TICK_DIV) == 0);
    end

    for (int i = 3; i < 16; i++) add_vec(2'd0, N_LED'(i));
    add_vec(2'd0, 4'b0000);
    for (int i = 0; i < 8; i++) add_vec(2'd1, scan_exp[i]);
    add_vec(2'd3, 4'b0000);
    add_vec(2'd0, 4'b0000);
    add_vec(2'd0, 4'b0001);
    add_vec(2'd0, 4'b0010);
`ifndef LED_PATTERN_BREATHE_EN
    add_vec(2'd2, 4'b0000);
    add_vec(2'd2, 4'b0000);
`endif
    foreach (vt[i]) begin
      to_tick(vt[i].mode);
      cyc(vt[i].mode, 1'b0);
      chk("table_led", led, vt[i].led);
    end

    // Only the mode present at the tick is loaded.
    to_tick(2'd0);
    to_tick(2'd0);
    cyc(2'd0, 1'b0);
    while (m_pre != TICK_DIV - 1) cyc(2'd1, 1'b0);
    cyc(2'd3, 1'b0);
    cyc(2'd3, 1'b0);
    chk("mode_latch_led", led, 0);

    // Pause mid-SCAN, including right at the would-be tick cycle.
    to_tick(2'd1);
    to_tick(2'd1);
    for (int h = 0; h < 2; h++) begin
      while (m_pre != hold_pts[h]) cyc(2'd1, 1'b0);
      hold = led;
      repeat (10) begin
        cycle(2'd1, 1'b1, tk);
        chk("pause_tick", tk, 0);
        chk("pause_led", led, hold);
      end
      n  = 0;
      tk = 1'b0;
      while (!tk && n < 4 * TICK_DIV) begin
        cycle(2'd1, 1'b0, tk);
        n++;
      end
      chk("resume_latency", n, TICK_DIV - hold_pts[h]);
    end

`ifdef LED_PATTERN_BREATHE_EN
    // Duty per tick measured as led-high cycles over a paused 256-cycle window.
    for (int i = 0; i < 10; i++) begin
      to_tick(2'd2);
      cyc(2'd2, 1'b1);
      hi = 0;
      repeat (256) begin
        cyc(2'd2, 1'b1);
        if (led == {N_LED{1'b1}}) hi++;
      end
      chk("breathe_duty", hi, breathe_exp[i]);
    end
    cur = 2'd2;
`else
    to_tick(2'd0);
    to_tick(2'd0);
    cur = 2'd0;
`endif

    // Asynchronous reset mid-pattern, then COUNT restart regardless of mode at release.
    n = 0;
    while (led == '0 && n < 600) begin
      cyc(cur, 1'b0);
      n++;
    end
    chk("led_lit_before_rst", led != '0, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_led", led, 0);
    chk("async_rst_tick", tick, 0);
    model_reset();
    @(negedge clk);
    mode = 2'd2;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= TICK_DIV; i++) begin
      cycle((i <= 2) ? 2'd2 : 2'd0, 1'b0, tk);
      chk("post_rst_tick", tk, i == TICK_DIV);
    end
    cyc(2'd0, 1'b0);
    chk("post_rst_led", led, 4'b0001);
    to_tick(2'd0);
    cyc(2'd0, 1'b0);
    chk("post_rst_led2", led, 4'b0010);

    // Randomized run against the model, with occasional async reset pulses.
    rm = 2'd0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        #3 rst = 1'b1;
        #1;
        chk("rand_rst_led", led, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end else begin
        cyc(rm, $urandom_range(0, 4) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule
